win_seq_ctrl: RTL and testbench



---
 rtl/win_seq_pkg.sv | 21 ++
 rtl/win_seq_if.sv | 12 +
 rtl/win_pos_cnt.sv | 51 +++++
 rtl/win_seq_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_win_seq_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/win_seq_pkg.sv
// rtl/win_seq_pkg.sv - shared types and constants for the window sequencer
package win_seq_pkg;

  localparam int IMG_W_DEF    = 480;
  localparam int IMG_H_DEF    = 270;
  localparam int WIN_ROWS_DEF = 8;
  localparam int DW_DEF       = 24;

  // Coordinate width covers both 0..479 columns and 0..269 rows
  localparam int CW            = 9;
  localparam int GAP_CYC       = 2;
  localparam int WIN_PER_FRAME = IMG_W_DEF * (IMG_H_DEF - WIN_ROWS_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } state_e;

endpackage

// File: rtl/win_seq_if.sv
// rtl/win_seq_if.sv - raw pixel stream handshake between source and sequencer
interface win_seq_if #(
  parameter int DW = 24
) ();
  logic [DW-1:0] pix_din;
  logic          pix_valid;
  logic          pix_sof;
  logic          pix_ready;

  modport master (output pix_din, pix_valid, pix_sof, input pix_ready);
  modport slave  (input pix_din, pix_valid, pix_sof, output pix_ready);
endinterface

// File: rtl/win_pos_cnt.sv
// rtl/win_pos_cnt.sv - column/row position counter with clear, wrap and last-pixel flag
module win_pos_cnt
  import win_seq_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          last
);

  logic [CW-1:0] col_q, col_d, row_q, row_d;

  // Next position: clear wins over count; column wraps into the next row
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == CW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (row_q == CW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

endmodule

// File: rtl/win_seq_ctrl.sv
// rtl/win_seq_ctrl.sv - frame sequencer for the sliding-window line buffer (optional WIN_SEQ_STATS_EN)
module win_seq_ctrl
  import win_seq_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int WIN_ROWS = WIN_ROWS_DEF,
  parameter int DW       = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  win_seq_if.slave      pix,
  input  logic          win_ready,
  output logic          lb_frame_en,
  output logic [DW-1:0] lb_din,
  output logic          lb_din_en,
  output logic          win_valid,
  output logic [CW-1:0] win_col,
  output logic [CW-1:0] win_row,
  output logic          win_eof,
  output logic          err_sof,
  output logic          busy
`ifdef WIN_SEQ_STATS_EN
  ,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   drop_cnt,
  output logic [7:0]    abort_cnt
`endif
);

  state_e        state_q, state_d;
  logic [1:0]    gap_q, gap_d;
  logic          lb_frame_en_q, lb_frame_en_d;
  logic [DW-1:0] lb_din_q, lb_din_d;
  logic          lb_din_en_q, lb_din_en_d;
  logic          s1_valid_q, s1_valid_d, s1_eof_q, s1_eof_d;
  logic [CW-1:0] s1_col_q, s1_col_d, s1_row_q, s1_row_d;
  logic          win_valid_q, win_valid_d, win_eof_q, win_eof_d;
  logic [CW-1:0] win_col_q, win_col_d, win_row_q, win_row_d;
  logic          err_sof_q, err_sof_d;
  logic          busy_q, busy_d;

  logic          ready, accept, sof_req, start, abort, shift, go_gap;
  logic          cnt_clr;
  logic [CW-1:0] pos_col, pos_row;
  logic          pos_last;

  assign sof_req = pix.pix_valid && pix.pix_sof;
  assign accept  = pix.pix_valid && ready;
  assign start   = (state_q == IDLE) && accept && pix.pix_sof;
  assign abort   = ((state_q == PRIME) || (state_q == STREAM)) && sof_req;
  // Pixels taken into the frame; non-SOF pixels accepted in IDLE are dropped
  assign shift   = start || (accept && (state_q != IDLE));
  // Counter sits at 0 between frames so the SOF pixel lands on (0,0)
  assign cnt_clr = (state_q == GAP) || ((state_q == IDLE) && !start);

  win_pos_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (shift),
    .col  (pos_col),
    .row  (pos_row),
    .last (pos_last)
  );

  // Input ready: streaming follows downstream, a new SOF mid-frame is held off
  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      PRIME:   ready = !sof_req;
      STREAM:  ready = win_ready && !sof_req;
      default: ready = 1'b0;
    endcase
    if (!rst_n) ready = 1'b0;
  end

  assign pix.pix_ready = ready;

  // Frame FSM, line-buffer feed and two-stage window coordinate pipeline
  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    lb_frame_en_d = lb_frame_en_q;
    lb_din_d      = lb_din_q;
    lb_din_en_d   = 1'b0;
    s1_valid_d    = 1'b0;
    s1_col_d      = s1_col_q;
    s1_row_d      = s1_row_q;
    s1_eof_d      = 1'b0;
    win_valid_d   = s1_valid_q;
    win_col_d     = s1_valid_q ? s1_col_q : win_col_q;
    win_row_d     = s1_valid_q ? s1_row_q : win_row_q;
    win_eof_d     = s1_eof_q;
    err_sof_d     = 1'b0;
    go_gap        = 1'b0;

    if (shift) begin
      lb_din_d    = pix.pix_din;
      lb_din_en_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = PRIME;
          lb_frame_en_d = 1'b1;
        end
      end
      PRIME: begin
        if (abort) begin
          go_gap    = 1'b1;
          err_sof_d = 1'b1;
        end else if (accept && (pos_col == CW'(IMG_W - 1)) &&
                     (pos_row == CW'(WIN_ROWS - 2))) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (abort) begin
          go_gap    = 1'b1;
          err_sof_d = 1'b1;
        end else if (accept) begin
          s1_valid_d = 1'b1;
          s1_col_d   = pos_col;
          s1_row_d   = pos_row;
          s1_eof_d   = pos_last;
          go_gap     = pos_last;
        end
      end
      GAP: begin
        if (gap_q == 2'(GAP_CYC - 1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_gap) begin
      state_d       = GAP;
      gap_d         = '0;
      lb_frame_en_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset discards any windows in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gap_q         <= '0;
      lb_frame_en_q <= 1'b0;
      lb_din_q      <= '0;
      lb_din_en_q   <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_col_q      <= '0;
      s1_row_q      <= '0;
      s1_eof_q      <= 1'b0;
      win_valid_q   <= 1'b0;
      win_col_q     <= '0;
      win_row_q     <= '0;
      win_eof_q     <= 1'b0;
      err_sof_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      lb_frame_en_q <= lb_frame_en_d;
      lb_din_q      <= lb_din_d;
      lb_din_en_q   <= lb_din_en_d;
      s1_valid_q    <= s1_valid_d;
      s1_col_q      <= s1_col_d;
      s1_row_q      <= s1_row_d;
      s1_eof_q      <= s1_eof_d;
      win_valid_q   <= win_valid_d;
      win_col_q     <= win_col_d;
      win_row_q     <= win_row_d;
      win_eof_q     <= win_eof_d;
      err_sof_q     <= err_sof_d;
      busy_q        <= busy_d;
    end
  end

  assign lb_frame_en = lb_frame_en_q;
  assign lb_din      = lb_din_q;
  assign lb_din_en   = lb_din_en_q;
  assign win_valid   = win_valid_q;
  assign win_col     = win_col_q;
  assign win_row     = win_row_q;
  assign win_eof     = win_eof_q;
  assign err_sof     = err_sof_q;
  assign busy        = busy_q;

`ifdef WIN_SEQ_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [7:0]  abort_cnt_q, abort_cnt_d;

  // Frame counter wraps; drop and abort counters saturate
  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, s1_eof_q};
    drop_cnt_d  = drop_cnt_q;
    abort_cnt_d = abort_cnt_q;
    if ((state_q == IDLE) && accept && !pix.pix_sof && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 1'b1;
    if (abort && (abort_cnt_q != 8'hFF))
      abort_cnt_d = abort_cnt_q + 1'b1;
  end

  // Statistics registers, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      abort_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_win_seq_ctrl.sv
// tb/tb_win_seq_ctrl.sv - directed self-checking bench for win_seq_ctrl on a reduced frame size
module tb_win_seq_ctrl;
  import win_seq_pkg::*;

  localparam int W    = 20;
  localparam int H    = 12;
  localparam int WR   = 8;
  localparam int DW   = 24;
  localparam int NWIN = W * (H - WR + 1);  // 100 windows per frame
  localparam int LIM  = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic win_ready = 1'b1;
  logic lb_frame_en, lb_din_en, win_valid, win_eof, err_sof, busy;
  logic [DW-1:0] lb_din;
  logic [CW-1:0] win_col, win_row;
`ifdef WIN_SEQ_STATS_EN
  logic [15:0] frame_cnt, drop_cnt;
  logic [7:0]  abort_cnt;
`endif

  always #5 clk = ~clk;

  win_seq_if #(.DW(DW)) pix_if ();

  win_seq_ctrl #(.IMG_W(W), .IMG_H(H), .WIN_ROWS(WR), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix        (pix_if),
    .win_ready  (win_ready),
    .lb_frame_en(lb_frame_en),
    .lb_din     (lb_din),
    .lb_din_en  (lb_din_en),
    .win_valid  (win_valid),
    .win_col    (win_col),
    .win_row    (win_row),
    .win_eof    (win_eof),
    .err_sof    (err_sof),
    .busy       (busy)
`ifdef WIN_SEQ_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .abort_cnt  (abort_cnt)
`endif
  );

  typedef struct {
    int t;
    int r;
    int c;
    bit eof;
  } win_t;

  win_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;
  bit src_on = 1'b0;
  int src_row = 0, src_col = 0;
  int win_cnt = 0, eof_cnt = 0;
  int t_acc = 0, t_first = 0, first_r = -1, first_c = -1;

  function automatic logic [DW-1:0] pix_val(input int r, input int c);
    return DW'(24'hC00000 + r * 256 + c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic drive();
    pix_if.pix_valid = src_on;
    pix_if.pix_sof   = src_on && (src_row == 0) && (src_col == 0);
    pix_if.pix_din   = src_on ? pix_val(src_row, src_col) : '0;
  endtask

  // One clock: check windows and record accepts at negedge, redrive after posedge
  task automatic cyc();
    bit exp_v;
    @(negedge clk);
    cycle++;
    exp_v = (q.size() > 0) && (q[0].t == cycle);
    if (exp_v) begin
      chk("win_valid", win_valid, 1);
      chk("win_row", win_row, q[0].r);
      chk("win_col", win_col, q[0].c);
      chk("win_eof", win_eof, q[0].eof);
      if (win_valid === 1'b1) begin
        if (win_cnt == 0) begin
          t_first = cycle;
          first_r = win_row;
          first_c = win_col;
        end
        win_cnt++;
        if (win_eof === 1'b1) eof_cnt++;
      end
      void'(q.pop_front());
    end else if (win_valid !== 1'b0) begin
      chk("win_unexpected", win_valid, 0);
    end
    if (rst_n && src_on && pix_if.pix_valid && (pix_if.pix_ready === 1'b1)) begin
      if (src_row == WR - 1 && src_col == 0) t_acc = cycle;
      if (src_row >= WR - 1)
        q.push_back('{cycle + 2, src_row, src_col, (src_row == H - 1 && src_col == W - 1)});
      if (src_col == W - 1) begin
        src_col = 0;
        if (src_row == H - 1) begin
          src_on  = 1'b0;
          src_row = 0;
        end else begin
          src_row++;
        end
      end else begin
        src_col++;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic start_frame();
    src_on  = 1'b1;
    src_row = 0;
    src_col = 0;
    win_cnt = 0;
    eof_cnt = 0;
    drive();
  endtask

  task automatic run_until(input int r, input int c);
    int n = 0;
    while (!(src_row == r && src_col == c) && n < LIM) begin
      cyc();
      n++;
    end
    chk("run_until_timeout", n >= LIM, 0);
  endtask

  task automatic finish_frame(input string tag);
    int n = 0;
    while ((src_on || q.size() > 0) && n < LIM) begin
      cyc();
      n++;
    end
    while (busy !== 1'b0 && n < LIM) begin
      cyc();
      n++;
    end
    chk({tag, "_timeout"}, n >= LIM, 0);
    chk({tag, "_win_total"}, win_cnt, NWIN);
    chk({tag, "_eof_count"}, eof_cnt, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    #1;
    chk({tag, "_lb_frame_en"}, lb_frame_en, 0);
    chk({tag, "_lb_din"}, lb_din, 0);
    chk({tag, "_lb_din_en"}, lb_din_en, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win_col"}, win_col, 0);
    chk({tag, "_win_row"}, win_row, 0);
    chk({tag, "_win_eof"}, win_eof, 0);
    chk({tag, "_err_sof"}, err_sof, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pix_ready"}, pix_if.pix_ready, 0);
`ifdef WIN_SEQ_STATS_EN
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
    chk({tag, "_abort_cnt"}, abort_cnt, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    pix_if.pix_valid = 1'b0;
    pix_if.pix_sof   = 1'b0;
    pix_if.pix_din   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("idle_ready", pix_if.pix_ready, 1);

    // Ten pixels without SOF are dropped in IDLE
    for (int i = 0; i < 10; i++) begin
      pix_if.pix_valid = 1'b1;
      pix_if.pix_sof   = 1'b0;
      pix_if.pix_din   = DW'(i + 1);
      #1;
      chk("drop_ready", pix_if.pix_ready, 1);
      cyc();
      chk("drop_no_din_en", lb_din_en, 0);
    end
    chk("drop_busy", busy, 0);
`ifdef WIN_SEQ_STATS_EN
    chk("drop_cnt", drop_cnt, 10);
`endif

    // Clean frame, continuous valid, downstream always ready
    start_frame();
    cyc();
    chk("sof_frame_en", lb_frame_en, 1);
    chk("sof_busy", busy, 1);
    chk("sof_din_en", lb_din_en, 1);
    chk("sof_din", lb_din, pix_val(0, 0));
    run_until(2, 3);
    cyc();
    chk("pix_2_3_din", lb_din, pix_val(2, 3));
    chk("pix_2_3_din_en", lb_din_en, 1);
    n = 0;
    while (src_on && n < LIM) begin
      cyc();
      n++;
    end
    #1;
    chk("gap1_busy", busy, 1);
    chk("gap1_frame_en", lb_frame_en, 0);
    chk("gap1_ready", pix_if.pix_ready, 0);
    cyc();
    #1;
    chk("gap2_busy", busy, 1);
    chk("gap2_frame_en", lb_frame_en, 0);
    chk("gap2_ready", pix_if.pix_ready, 0);
    cyc();
    #1;
    chk("gap_end_busy", busy, 0);
    chk("gap_end_frame_en", lb_frame_en, 0);
    chk("gap_end_ready", pix_if.pix_ready, 1);
    finish_frame("clean");
    chk("first_win_latency", t_first - t_acc, 2);
    chk("first_win_row", first_r, WR - 1);
    chk("first_win_col", first_c, 0);
`ifdef WIN_SEQ_STATS_EN
    chk("frame_cnt_1", frame_cnt, 1);
    chk("drop_cnt_kept", drop_cnt, 10);
`endif

    // Downstream stall for 5 cycles at row 9, col 5
    start_frame();
    run_until(9, 5);
    win_ready = 1'b0;
    #1;
    chk("stall_ready", pix_if.pix_ready, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      chk("stall_no_din_en", lb_din_en, 0);
      chk("stall_ready_held", pix_if.pix_ready, 0);
    end
    win_ready = 1'b1;
    finish_frame("stall");

    // Premature SOF at row 9, col 13
    start_frame();
    run_until(9, 13);
    src_row = 0;
    src_col = 0;
    drive();
    #1;
    chk("abort_ready", pix_if.pix_ready, 0);
    cyc();
    chk("abort_err_sof", err_sof, 1);
    chk("abort_frame_en", lb_frame_en, 0);
    chk("abort_busy", busy, 1);
    cyc();
    #1;
    chk("abort_err_pulse", err_sof, 0);
    chk("abort_gap_frame_en", lb_frame_en, 0);
    chk("abort_gap_ready", pix_if.pix_ready, 0);
    cyc();
    #1;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_ready", pix_if.pix_ready, 1);
    chk("abort_idle_frame_en", lb_frame_en, 0);
    chk("abort_no_eof", eof_cnt, 0);
`ifdef WIN_SEQ_STATS_EN
    chk("abort_cnt", abort_cnt, 1);
`endif
    win_cnt = 0;
    eof_cnt = 0;
    first_r = -1;
    first_c = -1;
    finish_frame("after_abort");
    chk("after_abort_first_row", first_r, WR - 1);
    chk("after_abort_first_col", first_c, 0);
    chk("after_abort_latency", t_first - t_acc, 2);

    // One-cycle reset in the middle of streaming
    start_frame();
    run_until(8, 4);
    rst_n = 1'b0;
    cyc();
    q.delete();
    src_on = 1'b0;
    drive();
    chk_all_zero("midreset");
    rst_n = 1'b1;
    start_frame();
    finish_frame("post_reset");

    // win_ready toggling during priming does not throttle input
    start_frame();
    n = 0;
    while (src_row < WR - 1 && n < 500) begin
      win_ready = ~win_ready;
      #1;
      chk("prime_ready", pix_if.pix_ready, 1);
      cyc();
      n++;
    end
    chk("prime_accepts", n, (WR - 1) * W);
    win_ready = 1'b0;
    #1;
    chk("stream_ready_low", pix_if.pix_ready, 0);
    win_ready = 1'b1;
    #1;
    chk("stream_ready_high", pix_if.pix_ready, 1);
    finish_frame("toggle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
